// File: rtl/doorlock_entry_ctrl_if.sv
// Key digit handshake between the keypad front end and the doorlock entry sequencer.
// The keypad (master) presents a digit with KEY_VALID; the sequencer (slave) takes it when KEY_READY is high.
interface doorlock_entry_ctrl_if;
  logic       KEY_VALID;
  logic [3:0] KEY_DATA;
  logic       KEY_READY;

  modport master (output KEY_VALID, output KEY_DATA, input KEY_READY);
  modport slave  (input KEY_VALID, input KEY_DATA, output KEY_READY);
endinterface

// File: rtl/doorlock_entry_ctrl.sv
// Doorlock keypad sequencer: serializes each accepted digit into the external shift register,
// verifies the readback, checks the entry against CODE, and runs the unlock/lockout timing.
module doorlock_entry_ctrl #(
  parameter int CODE_DIGITS    = 4,
  parameter int MAX_FAILS      = 3,
  parameter int UNLOCK_CYCLES  = 500,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic                        CLK,
  input  logic                        RST,
  doorlock_entry_ctrl_if.slave        key_if,
  input  logic                        CLEAR,
  input  logic [15:0]                 CODE,
  output logic                        SER_DIN,
  output logic                        SHIFT_EN,
  input  logic [3:0]                  REG_Q,
  output logic                        UNLOCK,
  output logic                        ALARM,
  output logic                        ENTRY_ERR,
  output logic                        XFER_ERR,
  output logic [1:0]                  FAIL_CNT
);

  // One down-counter serves both OPEN and LOCK, so it is sized for the longer of the two.
  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, EVAL, OPEN, LOCK} state_t;

  state_t        state_q, state_d;
  logic [3:0]    digit_q, digit_d;
  logic [1:0]    idx_q, idx_d;
  logic [2:0]    digit_cnt_q, digit_cnt_d;
  logic          mismatch_q, mismatch_d;
  logic [1:0]    fail_cnt_q, fail_cnt_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [3:0]    code_nibble;
  logic [1:0]    fail_next;
  logic          key_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      digit_q     <= '0;
      idx_q       <= '0;
      digit_cnt_q <= '0;
      mismatch_q  <= 1'b0;
      fail_cnt_q  <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      digit_q     <= digit_d;
      idx_q       <= idx_d;
      digit_cnt_q <= digit_cnt_d;
      mismatch_q  <= mismatch_d;
      fail_cnt_q  <= fail_cnt_d;
      timer_q     <= timer_d;
    end
  end

  // The first digit entered is matched against the most significant nibble of CODE.
  always_comb begin
    code_nibble = CODE[15:12];
    case (digit_cnt_q[1:0])
      2'd0:    code_nibble = CODE[15:12];
      2'd1:    code_nibble = CODE[11:8];
      2'd2:    code_nibble = CODE[7:4];
      default: code_nibble = CODE[3:0];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    digit_d     = digit_q;
    idx_d       = idx_q;
    digit_cnt_d = digit_cnt_q;
    mismatch_d  = mismatch_q;
    fail_cnt_d  = fail_cnt_q;
    timer_d     = timer_q;
    fail_next   = fail_cnt_q;
    key_ready   = 1'b0;
    SER_DIN     = 1'b0;
    SHIFT_EN    = 1'b0;
    UNLOCK      = 1'b0;
    ALARM       = 1'b0;
    ENTRY_ERR   = 1'b0;
    XFER_ERR    = 1'b0;

    case (state_q)
      IDLE: begin
        key_ready = 1'b1;
        if (CLEAR) begin
          digit_cnt_d = '0;
          mismatch_d  = 1'b0;
        end else if (key_if.KEY_VALID) begin
          digit_d = key_if.KEY_DATA;
          idx_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        SHIFT_EN = 1'b1;
        SER_DIN  = digit_q[idx_q];
        idx_d    = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = CHECK;
      end

      // A bad readback and a wrong digit both doom the entry, but only the former flags the datapath.
      CHECK: begin
        if (REG_Q != digit_q) begin
          XFER_ERR   = 1'b1;
          mismatch_d = 1'b1;
        end
        if (digit_q != code_nibble) mismatch_d = 1'b1;
        digit_cnt_d = digit_cnt_q + 3'd1;
        if (digit_cnt_q + 3'd1 == 3'(CODE_DIGITS)) state_d = EVAL;
        else                                       state_d = IDLE;
      end

      EVAL: begin
        digit_cnt_d = '0;
        mismatch_d  = 1'b0;
        if (!mismatch_q) begin
          fail_cnt_d = '0;
          timer_d    = TW'(UNLOCK_CYCLES - 1);
          state_d    = OPEN;
        end else begin
          ENTRY_ERR  = 1'b1;
          fail_next  = (fail_cnt_q >= 2'(MAX_FAILS)) ? fail_cnt_q : fail_cnt_q + 2'd1;
          fail_cnt_d = fail_next;
          if (fail_next == 2'(MAX_FAILS)) begin
            timer_d = TW'(LOCKOUT_CYCLES - 1);
            state_d = LOCK;
          end else begin
            state_d = IDLE;
          end
        end
      end

      OPEN: begin
        UNLOCK = 1'b1;
        if (timer_q == '0) state_d = IDLE;
        else               timer_d = timer_q - TW'(1);
      end

      LOCK: begin
        ALARM = 1'b1;
        if (timer_q == '0) begin
          fail_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign key_if.KEY_READY = key_ready;
  assign FAIL_CNT         = fail_cnt_q;

endmodule

// File: tb/tb_doorlock_entry_ctrl.sv
// Directed bench for doorlock_entry_ctrl with a behavioral model of the external 4-bit shift register.
// Expected values are hand-derived from the entry timing (accept at T, SHIFT T+1..T+4, CHECK T+5).
module tb_doorlock_entry_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CLEAR;
  logic [15:0] CODE;
  logic        SER_DIN, SHIFT_EN, UNLOCK, ALARM, ENTRY_ERR, XFER_ERR;
  logic [1:0]  FAIL_CNT;
  logic [3:0]  REG_Q;
  logic [3:0]  shreg_q;
  logic        fault_zero;

  int total = 0;
  int bad   = 0;

  doorlock_entry_ctrl_if key_if();

  doorlock_entry_ctrl #(
    .CODE_DIGITS(4), .MAX_FAILS(3), .UNLOCK_CYCLES(500), .LOCKOUT_CYCLES(1000)
  ) dut (
    .CLK(CLK), .RST(RST), .key_if(key_if), .CLEAR(CLEAR), .CODE(CODE),
    .SER_DIN(SER_DIN), .SHIFT_EN(SHIFT_EN), .REG_Q(REG_Q), .UNLOCK(UNLOCK),
    .ALARM(ALARM), .ENTRY_ERR(ENTRY_ERR), .XFER_ERR(XFER_ERR), .FAIL_CNT(FAIL_CNT)
  );

  always #5 CLK = ~CLK;

  // Din enters Q3 and moves toward Q0, so four LSB-first shifts leave REG_Q equal to the digit.
  always @(posedge CLK) begin
    if (RST)           shreg_q <= 4'h0;
    else if (SHIFT_EN) shreg_q <= {SER_DIN, shreg_q[3:1]};
  end
  assign REG_Q = fault_zero ? 4'h0 : shreg_q;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Presents one digit from IDLE and returns at T+6; KEY_DATA is scrambled after acceptance.
  task automatic applyStimulus(input logic [3:0] d, output logic xfer);
    checkOutput("ready_before_key", 32'(key_if.KEY_READY), 1);
    key_if.KEY_VALID = 1'b1;
    key_if.KEY_DATA  = d;
    step();
    key_if.KEY_VALID = 1'b0;
    key_if.KEY_DATA  = ~d;
    for (int i = 0; i < 4; i++) begin
      checkOutput("shift_en", 32'(SHIFT_EN), 1);
      checkOutput("ser_din", 32'(SER_DIN), 32'(d[i]));
      checkOutput("ready_busy", 32'(key_if.KEY_READY), 0);
      step();
    end
    checkOutput("shift_en_check", 32'(SHIFT_EN), 0);
    xfer = XFER_ERR;
    step();
  endtask

  task automatic enterCode(input logic [15:0] keys, output logic xfer_any);
    logic x;
    xfer_any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(keys[15-4*k -: 4], x);
      xfer_any = xfer_any | x;
      if (k < 3) checkOutput("ready_between", 32'(key_if.KEY_READY), 1);
    end
  endtask

  task automatic waitUnlock(output int n, output int viol);
    n = 0;
    viol = 0;
    while (UNLOCK === 1'b1 && n < 600) begin
      if (key_if.KEY_READY !== 1'b0) viol++;
      n++;
      step();
    end
  endtask

  task automatic waitAlarm(output int n, output int viol);
    n = 0;
    viol = 0;
    while (ALARM === 1'b1 && n < 1100) begin
      if (key_if.KEY_READY !== 1'b0) viol++;
      n++;
      step();
    end
  endtask

  initial begin
    logic x;
    int   n, viol, accepts, shifts;

    RST = 1'b1;
    CLEAR = 1'b0;
    CODE = 16'h1234;
    key_if.KEY_VALID = 1'b0;
    key_if.KEY_DATA = 4'h0;
    fault_zero = 1'b0;

    step();
    checkOutput("rst_ready", 32'(key_if.KEY_READY), 1);
    checkOutput("rst_shift_en", 32'(SHIFT_EN), 0);
    checkOutput("rst_ser_din", 32'(SER_DIN), 0);
    checkOutput("rst_unlock", 32'(UNLOCK), 0);
    checkOutput("rst_alarm", 32'(ALARM), 0);
    checkOutput("rst_entry_err", 32'(ENTRY_ERR), 0);
    checkOutput("rst_xfer_err", 32'(XFER_ERR), 0);
    checkOutput("rst_fail_cnt", 32'(FAIL_CNT), 0);
    RST = 1'b0;
    step();

    // Correct code, with KEY_VALID held throughout OPEN.
    enterCode(16'h1234, x);
    checkOutput("ok_xfer", 32'(x), 0);
    checkOutput("ok_eval_entry_err", 32'(ENTRY_ERR), 0);
    checkOutput("ok_eval_ready", 32'(key_if.KEY_READY), 0);
    checkOutput("ok_eval_unlock", 32'(UNLOCK), 0);
    step();
    checkOutput("ok_unlock_rise", 32'(UNLOCK), 1);
    checkOutput("ok_fail_cnt", 32'(FAIL_CNT), 0);
    key_if.KEY_VALID = 1'b1;
    key_if.KEY_DATA = 4'h1;
    waitUnlock(n, viol);
    key_if.KEY_VALID = 1'b0;
    checkOutput("unlock_len", 32'(n), 500);
    checkOutput("open_ready_low", 32'(viol), 0);
    checkOutput("post_open_no_shift", 32'(SHIFT_EN), 0);
    checkOutput("post_open_ready", 32'(key_if.KEY_READY), 1);

    // Three wrong entries lead into lockout.
    for (int r = 1; r <= 3; r++) begin
      enterCode(16'h1235, x);
      checkOutput("bad_entry_err", 32'(ENTRY_ERR), 1);
      checkOutput("bad_xfer", 32'(x), 0);
      step();
      checkOutput("bad_entry_err_single", 32'(ENTRY_ERR), 0);
      checkOutput("bad_fail_cnt", 32'(FAIL_CNT), 32'(r));
      if (r < 3) checkOutput("bad_ready_back", 32'(key_if.KEY_READY), 1);
      else       checkOutput("alarm_rise", 32'(ALARM), 1);
    end
    waitAlarm(n, viol);
    checkOutput("alarm_len", 32'(n), 1000);
    checkOutput("lock_ready_low", 32'(viol), 0);
    checkOutput("post_lock_fail_cnt", 32'(FAIL_CNT), 0);
    checkOutput("post_lock_ready", 32'(key_if.KEY_READY), 1);

    // Readback forced to zero on the first digit: the entry fails even though the digits match.
    CODE = 16'hA234;
    fault_zero = 1'b1;
    applyStimulus(4'hA, x);
    fault_zero = 1'b0;
    checkOutput("fault_xfer_err", 32'(x), 1);
    applyStimulus(4'h2, x);
    checkOutput("fault_xfer_clean", 32'(x), 0);
    applyStimulus(4'h3, x);
    applyStimulus(4'h4, x);
    checkOutput("fault_entry_err", 32'(ENTRY_ERR), 1);
    step();
    checkOutput("fault_fail_cnt", 32'(FAIL_CNT), 1);
    checkOutput("fault_no_unlock", 32'(UNLOCK), 0);
    enterCode(16'hA234, x);
    step();
    checkOutput("fault_recover_unlock", 32'(UNLOCK), 1);
    checkOutput("fault_recover_fail_cnt", 32'(FAIL_CNT), 0);
    waitUnlock(n, viol);
    checkOutput("fault_recover_len", 32'(n), 500);

    // CLEAR after two wrong digits discards them.
    CODE = 16'h1234;
    applyStimulus(4'h9, x);
    applyStimulus(4'h9, x);
    CLEAR = 1'b1;
    step();
    CLEAR = 1'b0;
    enterCode(16'h1234, x);
    checkOutput("abort_entry_err", 32'(ENTRY_ERR), 0);
    step();
    checkOutput("abort_unlock", 32'(UNLOCK), 1);
    waitUnlock(n, viol);
    checkOutput("abort_unlock_len", 32'(n), 500);

    CLEAR = 1'b1;
    key_if.KEY_VALID = 1'b1;
    key_if.KEY_DATA = 4'h1;
    step();
    CLEAR = 1'b0;
    key_if.KEY_VALID = 1'b0;
    checkOutput("clear_blocks_accept", 32'(SHIFT_EN), 0);
    checkOutput("clear_ready", 32'(key_if.KEY_READY), 1);

    // KEY_VALID held: accepts land at T, T+6, T+12 within an 18-cycle window.
    accepts = 0;
    shifts = 0;
    key_if.KEY_VALID = 1'b1;
    key_if.KEY_DATA = 4'h7;
    for (int c = 0; c < 18; c++) begin
      if (key_if.KEY_VALID && key_if.KEY_READY && !CLEAR) accepts++;
      if (SHIFT_EN) shifts++;
      step();
    end
    key_if.KEY_VALID = 1'b0;
    checkOutput("held_accepts", 32'(accepts), 3);
    checkOutput("held_shift_cycles", 32'(shifts), 12);
    CLEAR = 1'b1;
    step();
    CLEAR = 1'b0;

    // Reset in the second SHIFT cycle with a nonzero fail count.
    enterCode(16'h1111, x);
    step();
    checkOutput("pre_rst_fail_cnt", 32'(FAIL_CNT), 1);
    key_if.KEY_VALID = 1'b1;
    key_if.KEY_DATA = 4'hF;
    step();
    key_if.KEY_VALID = 1'b0;
    step();
    checkOutput("mid_shift_en", 32'(SHIFT_EN), 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    checkOutput("mrst_shift_en", 32'(SHIFT_EN), 0);
    checkOutput("mrst_ser_din", 32'(SER_DIN), 0);
    checkOutput("mrst_ready", 32'(key_if.KEY_READY), 1);
    checkOutput("mrst_fail_cnt", 32'(FAIL_CNT), 0);
    checkOutput("mrst_unlock", 32'(UNLOCK), 0);
    checkOutput("mrst_alarm", 32'(ALARM), 0);
    checkOutput("mrst_entry_err", 32'(ENTRY_ERR), 0);
    checkOutput("mrst_xfer_err", 32'(XFER_ERR), 0);
    enterCode(16'h1234, x);
    step();
    checkOutput("mrst_then_unlock", 32'(UNLOCK), 1);
    waitUnlock(n, viol);
    checkOutput("mrst_unlock_len", 32'(n), 500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
